// File: rtl/comparador_serial.sv
// rtl/comparador_serial.sv - bit-serial unsigned magnitude comparator, MSB first.
// Results hold until the next accepted start; busy marks COMPARE and done pulses once in DONE.
module comparador_serial #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic         maior,
   output logic         menor,
   output logic         igual
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COMPARE = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [N-1:0]  ra;
   logic [N-1:0]  rb;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         ra    <= '0;
         rb    <= '0;
         maior <= 1'b0;
         menor <= 1'b0;
         igual <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  idx   <= IW'(N - 1);
                  maior <= 1'b0;
                  menor <= 1'b0;
                  igual <= 1'b0;
                  state <= COMPARE;
               end
            end
            COMPARE: begin
               // The first differing bit decides; lower bits are never looked at.
               if (ra[idx] && !rb[idx]) begin
                  maior <= 1'b1;
                  state <= DONE;
               end else if (!ra[idx] && rb[idx]) begin
                  menor <= 1'b1;
                  state <= DONE;
               end else if (idx == '0) begin
                  igual <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == COMPARE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_comparador_serial.sv
// tb/tb_comparador_serial.sv - directed bench for comparador_serial with a per-cycle reference model.
module tb_comparador_serial;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic         maior;
   logic         menor;
   logic         igual;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   comparador_serial #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .maior (maior),
      .menor (menor),
      .igual (igual)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference: rem counts cycles left until idle; the result is known at accept time.
   int       m_rem = 0;
   logic [2:0] m_flags = 3'b000;
   logic [2:0] m_pend  = 3'b000;

   function automatic int first_diff(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [N-1:0] d;
      d = x ^ y;
      for (int i = N - 1; i >= 0; i--)
         if (d[i]) return N - i;
      return N;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_rem   = 0;
         m_flags = 3'b000;
      end else if (m_rem == 0) begin
         if (start) begin
            m_rem   = first_diff(a, b) + 1;
            m_flags = 3'b000;
            m_pend  = (a > b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
         end
      end else begin
         m_rem--;
         if (m_rem == 1) m_flags = m_pend;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cycle_outputs", {busy, done, maior, menor, igual},
               {(m_rem > 1), (m_rem == 1), m_flags});
         if (done) check("onehot_at_done", $countones({maior, menor, igual}), 1);
      end
   end

   task automatic op(input logic [N-1:0] va, input logic [N-1:0] vb,
                     input logic [2:0] exp_flags, input int exp_lat, input string nm);
      int lat;
      @(negedge clk);
      a = va; b = vb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({nm, "_latency"}, lat, exp_lat);
      check({nm, "_flags"}, {maior, menor, igual}, exp_flags);
   endtask

   initial begin
      int ndone;
      int last_done;
      int gap;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_state", {busy, done, maior, menor, igual}, 5'b00000);

      op(8'hA5, 8'hA5, 3'b001, 9, "equal");
      op(8'h80, 8'h7F, 3'b100, 2, "msb_diff");
      repeat (5) @(negedge clk);
      check("flags_held", {busy, done, maior, menor, igual}, 5'b00100);
      op(8'h3C, 8'h3D, 3'b010, 9, "lsb_diff");
      op(8'h01, 8'h00, 3'b100, 9, "lsb_maior");
      op(8'h00, 8'h40, 3'b010, 3, "bit6_menor");

      // Operand changes and a stray start while busy must not disturb the result.
      @(negedge clk);
      a = 8'h10; b = 8'h20; start = 1'b1;
      @(negedge clk);
      a = 8'hFF; b = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = (done) ? 1 : 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            check("busy_change_flags", {maior, menor, igual}, 3'b010);
         end
      end
      check("busy_change_done_count", ndone, 1);

      // Reset three edges into a comparison of equal operands.
      @(negedge clk);
      a = 8'h01; b = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("after_reset", {busy, done, maior, menor, igual}, 5'b00000);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("aborted_no_done", ndone, 0);
      op(8'h02, 8'h01, 3'b100, 8, "post_reset");

      // Start held high: a new accept follows each DONE cycle.
      @(negedge clk);
      a = 8'h00; b = 8'hFF; start = 1'b1;
      ndone = 0; last_done = 0;
      for (int i = 0; i < 20 && ndone < 3; i++) begin
         @(negedge clk);
         if (done) begin
            check("b2b_flags", {maior, menor, igual}, 3'b010);
            if (ndone > 0) begin
               gap = cyc - last_done;
               check("b2b_gap", gap, 3);
            end
            last_done = cyc;
            ndone++;
         end
      end
      check("b2b_pulses", ndone, 3);
      start = 1'b0;
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
